dmem_arbiter: RTL

//  Shares one single-port data memory bus between the core's load/store port and an

---
 rtl/dmem_arbiter_pkg.sv | 48 ++++
 rtl/dmem_arbiter_starve.sv | 51 +++++
 rtl/dmem_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared types, defaults and helpers for the data-memory arbiter.
//            Provides the FSM state encoding, the latched memory command
//            layout, default window/starvation parameters and the address
//            window check used on both request ports.
// Revision : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

    // FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CORE_REQ  = 3'd1,
        ST_CORE_RSP  = 3'd2,
        ST_CORE_DONE = 3'd3,
        ST_EXT_REQ   = 3'd4,
        ST_EXT_RSP   = 3'd5,
        ST_EXT_ERR   = 3'd6
    } arb_state_t;

    // Command captured from the winning requester and driven onto mem_*
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_cmd_t;

    localparam logic [31:0] c_default_addr_base    = 32'h0000_0000;
    localparam logic [31:0] c_default_addr_size    = 32'h0001_0000;
    localparam int          c_default_starve_limit = 4;

    // Unsigned offset compare: an address below the base wraps to a huge
    // offset and therefore lands out of range, as does base+size and above.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] size
    );
        logic [31:0] offset;
        offset = addr - base;
        return (offset < size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_starve.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_starve
// Purpose  : Saturating starvation counter and core/ext priority decision.
//            The core normally wins a simultaneous request; every core win
//            while the external port waits bumps the counter, and once it
//            reaches STARVE_LIMIT the external port wins the next decision.
// Ports    : clk, reset (async, active-low)
//            core_req  - core request pending
//            ext_req   - external request pending
//            idle      - arbiter is in IDLE and will decide this cycle
//            ext_wins  - external port is selected this cycle
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic core_req,
    input  logic ext_req,
    input  logic idle,
    output logic ext_wins
);

    localparam int c_cnt_w = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_starved;

    assign w_starved = (r_cnt >= c_limit);

    // External wins when it is alone, or when the core has starved it.
    assign ext_wins = idle & ext_req & (~core_req | w_starved);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (idle) begin
            if (ext_wins || !ext_req) begin
                r_cnt <= '0;
            end else if (core_req && !w_starved) begin
                // core won against a waiting external request
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one single-port data memory bus between the core
//            load/store port and an external (DMA/debug) master. Every access
//            runs through the memory req/gnt/rvalid handshake with at most
//            one transaction outstanding. The core is stalled until its
//            access completes; out-of-window addresses fault without touching
//            memory.
// Ports    : clk, reset (async, active-low)
//            Core : req_mem, wmem_o, addr_o, data_o, wmask -> data_stall,
//                   data_i, data_err
//            Ext  : ext_req, ext_we, ext_addr, ext_wdata, ext_be -> ext_gnt,
//                   ext_rvalid, ext_rdata, ext_err
//            Mem  : mem_req, mem_we, mem_addr, mem_wdata, mem_be <- mem_gnt,
//                   mem_rvalid, mem_rdata, mem_err
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = c_default_addr_base,
    parameter logic [31:0] ADDR_SIZE    = c_default_addr_size,
    parameter int          STARVE_LIMIT = c_default_starve_limit
) (
    input  logic        clk,
    input  logic        reset,
    // core port
    input  logic        req_mem,
    input  logic        wmem_o,
    input  logic [31:0] addr_o,
    input  logic [31:0] data_o,
    input  logic [3:0]  wmask,
    output logic        data_stall,
    output logic [31:0] data_i,
    output logic        data_err,
    // external master port
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [3:0]  ext_be,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic        ext_err,
    // memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    arb_state_t  r_state;
    mem_cmd_t    r_cmd;
    logic [31:0] r_data_i;
    logic        r_err;

    logic        w_idle;
    logic        w_ext_win;
    logic        w_core_ok;
    logic        w_ext_ok;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_core_ok = addr_in_range(addr_o, ADDR_BASE, ADDR_SIZE);
    assign w_ext_ok  = addr_in_range(ext_addr, ADDR_BASE, ADDR_SIZE);

    dmem_arbiter_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .core_req (req_mem),
        .ext_req  (ext_req),
        .idle     (w_idle),
        .ext_wins (w_ext_win)
    );

    // ------------------------------------------------------------------
    // FSM + datapath. Request fields are sampled only on leaving IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cmd    <= '0;
            r_data_i <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ext_win) begin
                        r_cmd <= '{we: ext_we, addr: ext_addr, wdata: ext_wdata, be: ext_be};
                        r_state <= w_ext_ok ? ST_EXT_REQ : ST_EXT_ERR;
                    end else if (req_mem) begin
                        r_cmd <= '{we: wmem_o, addr: addr_o, wdata: data_o, be: wmask};
                        if (w_core_ok) begin
                            r_err   <= 1'b0;
                            r_state <= ST_CORE_REQ;
                        end else begin
                            // fault without a memory access
                            r_err   <= 1'b1;
                            r_state <= ST_CORE_DONE;
                        end
                    end
                end
                ST_CORE_REQ: begin
                    if (mem_gnt) begin
                        r_state <= ST_CORE_RSP;
                    end
                end
                ST_CORE_RSP: begin
                    if (mem_rvalid) begin
                        r_err <= mem_err;
                        if (!r_cmd.we) begin
                            r_data_i <= mem_rdata;
                        end
                        r_state <= ST_CORE_DONE;
                    end
                end
                ST_CORE_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_EXT_REQ: begin
                    if (mem_gnt) begin
                        r_state <= ST_EXT_RSP;
                    end
                end
                ST_EXT_RSP: begin
                    if (mem_rvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXT_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the state register
    // ------------------------------------------------------------------
    assign mem_req   = (r_state == ST_CORE_REQ) || (r_state == ST_EXT_REQ);
    assign mem_we    = r_cmd.we;
    assign mem_addr  = r_cmd.addr;
    assign mem_wdata = r_cmd.wdata;
    assign mem_be    = r_cmd.be;

    // Stall follows req_mem directly so the core sees it in the request cycle.
    assign data_stall = req_mem & (r_state != ST_CORE_DONE);
    assign data_err   = (r_state == ST_CORE_DONE) & r_err;
    assign data_i     = r_data_i;

    // ext_gnt is combinational so the master can drop ext_req before the
    // arbiter returns to IDLE and would otherwise sample it again.
    assign ext_gnt = ((r_state == ST_EXT_REQ) & mem_gnt) | (w_ext_win & ~w_ext_ok);

    always_comb begin
        ext_rvalid = 1'b0;
        ext_rdata  = '0;
        ext_err    = 1'b0;
        case (r_state)
            ST_EXT_RSP: begin
                ext_rvalid = mem_rvalid;
                ext_rdata  = mem_rdata;
                ext_err    = mem_err;
            end
            ST_EXT_ERR: begin
                ext_rvalid = 1'b1;
                ext_err    = 1'b1;
            end
            default: begin
                ext_rvalid = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
